// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: latches one request, starts the selected unit, waits for it, writes HI/LO.
// Optional build macro MULDIV_DBZ_BYPASS_EN: divide-by-zero skips the divider and writes a fixed result.
module muldiv_sched #(
  parameter int WATCHDOG = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        req_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mul_start,
  output logic        mulu_start,
  output logic        div_start,
  output logic        divu_start,
  input  logic        mul_done,
  input  logic        mulu_done,
  input  logic        div_busy,
  input  logic        divu_busy,
  input  logic [63:0] mul_res,
  input  logic [63:0] mulu_res,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        hilo_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dbz,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int CW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WATCHDOG - 1);

  state_t        state;
  logic [1:0]    op;
  logic [CW-1:0] cnt;
  logic          fin;
  logic [31:0]   fin_hi;
  logic [31:0]   fin_lo;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and req_valid is ignored everywhere else.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Dividers raise busy one cycle after start, so the first WAIT cycle cannot signal completion.
  always_comb begin
    fin    = 1'b0;
    fin_hi = 32'd0;
    fin_lo = 32'd0;
    case (op)
      2'b00: begin fin = mul_done;                    fin_hi = mul_res[63:32];  fin_lo = mul_res[31:0];  end
      2'b01: begin fin = mulu_done;                   fin_hi = mulu_res[63:32]; fin_lo = mulu_res[31:0]; end
      2'b10: begin fin = (cnt != '0) && !div_busy;    fin_hi = div_r;           fin_lo = div_q;          end
      default: begin fin = (cnt != '0) && !divu_busy; fin_hi = divu_r;          fin_lo = divu_q;         end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= 2'b00;
      cnt        <= '0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      mul_start  <= 1'b0;
      mulu_start <= 1'b0;
      div_start  <= 1'b0;
      divu_start <= 1'b0;
      hi_wdata   <= 32'd0;
      lo_wdata   <= 32'd0;
      hilo_we    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dbz        <= 1'b0;
    end else begin
      mul_start  <= 1'b0;
      mulu_start <= 1'b0;
      div_start  <= 1'b0;
      divu_start <= 1'b0;
      hi_wdata   <= 32'd0;
      lo_wdata   <= 32'd0;
      hilo_we    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dbz        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op   <= req_op;
            op_a <= rs_val;
            op_b <= rt_val;
            cnt  <= '0;
`ifdef MULDIV_DBZ_BYPASS_EN
            if (req_op[1] && (rt_val == 32'd0)) begin
              state    <= WRITE;
              hilo_we  <= 1'b1;
              done     <= 1'b1;
              dbz      <= 1'b1;
              hi_wdata <= rs_val;
              lo_wdata <= 32'hFFFF_FFFF;
            end else
`endif
            begin
              state      <= START;
              mul_start  <= (req_op == 2'b00);
              mulu_start <= (req_op == 2'b01);
              div_start  <= (req_op == 2'b10);
              divu_start <= (req_op == 2'b11);
            end
          end
        end
        START: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (fin) begin
            state    <= WRITE;
            hilo_we  <= 1'b1;
            done     <= 1'b1;
            hi_wdata <= fin_hi;
            lo_wdata <= fin_lo;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: mult/div paths, latency, operand hold, watchdog, reset, divide-by-zero.
module tb_muldiv_sched;
  localparam int WATCHDOG = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs_val, rt_val;
  logic        req_ready;
  logic [31:0] op_a, op_b;
  logic        mul_start, mulu_start, div_start, divu_start;
  logic        mul_done, mulu_done, div_busy, divu_busy;
  logic [63:0] mul_res, mulu_res;
  logic [31:0] div_q, div_r, divu_q, divu_r;
  logic [31:0] hi_wdata, lo_wdata;
  logic        hilo_we, busy, done, err, dbz;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  muldiv_sched #(.WATCHDOG(WATCHDOG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .rs_val(rs_val), .rt_val(rt_val), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b),
    .mul_start(mul_start), .mulu_start(mulu_start), .div_start(div_start), .divu_start(divu_start),
    .mul_done(mul_done), .mulu_done(mulu_done), .div_busy(div_busy), .divu_busy(divu_busy),
    .mul_res(mul_res), .mulu_res(mulu_res),
    .div_q(div_q), .div_r(div_r), .divu_q(divu_q), .divu_r(divu_r),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hilo_we(hilo_we),
    .busy(busy), .done(done), .err(err), .dbz(dbz), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval just after rising edge n; the request is presented in cycle 0.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic clear_inputs;
    req_valid = 1'b0; req_op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    mul_done = 1'b0; mulu_done = 1'b0; div_busy = 1'b0; divu_busy = 1'b0;
    mul_res = 64'd0; mulu_res = 64'd0;
    div_q = 32'd0; div_r = 32'd0; divu_q = 32'd0; divu_r = 32'd0;
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; rs_val = a; rt_val = b;
    cyc = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if ({busy, hilo_we, done, err, dbz, mul_start, mulu_start, div_start, divu_start} !== 9'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000000",
        {busy, hilo_we, done, err, dbz, mul_start, mulu_start, div_start, divu_start});
    end
    checks++;
    if ({op_a, op_b, hi_wdata, lo_wdata} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {op_a, op_b, hi_wdata, lo_wdata});
    end
    checks++;
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  // Signed -2 * 3 = -6; rst is released in the same cycle the request is presented.
  task automatic test_mult;
    int mul_seen = 0;
    int other_seen = 0;
    int early = 0;
    clear_inputs();
    request(2'b00, 32'hFFFF_FFFE, 32'd3);
    rst = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (mul_start) mul_seen++;
      if (mulu_start || div_start || divu_start) other_seen++;
      if (c >= 1 && c <= 5 && (hilo_we || done)) early++;
      if (c == 1) begin
        req_valid = 1'b0;
        checks++;
        if (mul_start !== 1'b1 || state_dbg !== 2'd1 || req_ready !== 1'b0) begin
          errors++; $display("FAIL mult_start_c1: got start=%b state=%0d ready=%b expected 1/1/0",
            mul_start, state_dbg, req_ready);
        end
      end
      if (c == 5) begin mul_done = 1'b1; mul_res = 64'hFFFF_FFFF_FFFF_FFFA; end
      if (c == 6) begin
        mul_done = 1'b0;
        checks++;
        if ({hilo_we, done, err, dbz} !== 4'b1100 || hi_wdata !== 32'hFFFF_FFFF || lo_wdata !== 32'hFFFF_FFFA) begin
          errors++; $display("FAIL mult_write_c6: got we/done/err/dbz=%b hi=%h lo=%h expected 1100 ffffffff fffffffa",
            {hilo_we, done, err, dbz}, hi_wdata, lo_wdata);
        end
      end
      if (c == 7) begin
        checks++;
        if (hilo_we !== 1'b0 || hi_wdata !== 32'd0 || lo_wdata !== 32'd0 || req_ready !== 1'b1) begin
          errors++; $display("FAIL mult_after: got we=%b hi=%h lo=%h ready=%b expected 0 0 0 1",
            hilo_we, hi_wdata, lo_wdata, req_ready);
        end
      end
    end
    checks++;
    if (mul_seen != 1 || other_seen != 0 || early != 0) begin
      errors++; $display("FAIL mult_pulses: got mul=%0d other=%0d early=%0d expected 1 0 0", mul_seen, other_seen, early);
    end
  endtask

  // Divider that never raises busy: the first WAIT cycle is ignored, so WRITE lands at cycle 4.
  task automatic test_div_min;
    int hw_at = -1;
    logic [31:0] hi_s = 32'd0, lo_s = 32'd0;
    clear_inputs();
    request(2'b10, 32'hFFFF_FFF9, 32'd2);
    div_q = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        req_valid = 1'b0;
        checks++;
        if (div_start !== 1'b1) begin errors++; $display("FAIL div_start: got %b expected 1", div_start); end
      end
      if (hilo_we && hw_at < 0) begin hw_at = c; hi_s = hi_wdata; lo_s = lo_wdata; end
    end
    checks++;
    if (hw_at != 4 || hi_s !== 32'hFFFF_FFFF || lo_s !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_min_latency: got cycle=%0d hi=%h lo=%h expected 4 ffffffff fffffffd", hw_at, hi_s, lo_s);
    end
  endtask

  // divu 100/7: busy is seen low from cycle 34, so WRITE is at cycle 35.
  task automatic test_divu;
    int hw_at = -1;
    int rdy_bad = 0;
    logic [31:0] hi_s = 32'd0, lo_s = 32'd0;
    clear_inputs();
    request(2'b11, 32'd100, 32'd7);
    divu_q = 32'd14; divu_r = 32'd2;
    for (int c = 1; c <= 36; c++) begin
      tick();
      divu_busy = (c >= 2 && c <= 33);
      if (c == 1) begin
        req_valid = 1'b0;
        checks++;
        if (divu_start !== 1'b1 || div_start !== 1'b0) begin
          errors++; $display("FAIL divu_start: got divu=%b div=%b expected 1 0", divu_start, div_start);
        end
      end
      if (c <= 35 && req_ready) rdy_bad++;
      if (hilo_we && hw_at < 0) begin hw_at = c; hi_s = hi_wdata; lo_s = lo_wdata; end
      if (c == 36) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL divu_ready_c36: got %b expected 1", req_ready); end
      end
    end
    checks++;
    if (hw_at != 35 || hi_s !== 32'd2 || lo_s !== 32'd14) begin
      errors++; $display("FAIL divu_write: got cycle=%0d hi=%h lo=%h expected 35 2 e", hw_at, hi_s, lo_s);
    end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL divu_ready_low: got %0d ready cycles expected 0", rdy_bad); end
  endtask

  // req_valid stays high; the second (multu) request must wait for the first to finish.
  task automatic test_back_to_back;
    int held_bad = 0;
    clear_inputs();
    request(2'b00, 32'd5, 32'd6);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin req_op = 2'b01; rs_val = 32'd11; rt_val = 32'd12; end
      if (c <= 5 && (op_a !== 32'd5 || op_b !== 32'd6)) held_bad++;
      if (c <= 5 && mulu_start) held_bad++;
      if (c >= 2 && c <= 5 && mul_start) held_bad++;
      if (c == 3) begin mul_done = 1'b1; mul_res = 64'd30; end
      if (c == 4) begin
        mul_done = 1'b0;
        checks++;
        if (hilo_we !== 1'b1 || hi_wdata !== 32'd0 || lo_wdata !== 32'd30) begin
          errors++; $display("FAIL b2b_first_write: got we=%b hi=%h lo=%h expected 1 0 1e", hilo_we, hi_wdata, lo_wdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c5: got %b expected 1", req_ready); end
      end
      if (c == 6) begin
        req_valid = 1'b0;
        checks++;
        if (mulu_start !== 1'b1 || op_a !== 32'd11 || op_b !== 32'd12) begin
          errors++; $display("FAIL b2b_second_accept: got start=%b a=%h b=%h expected 1 b c", mulu_start, op_a, op_b);
        end
      end
      if (c == 7) begin mulu_done = 1'b1; mulu_res = 64'd132; end
      if (c == 8) begin
        mulu_done = 1'b0;
        checks++;
        if (hilo_we !== 1'b1 || hi_wdata !== 32'd0 || lo_wdata !== 32'd132) begin
          errors++; $display("FAIL b2b_second_write: got we=%b hi=%h lo=%h expected 1 0 84", hilo_we, hi_wdata, lo_wdata);
        end
      end
    end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d violations expected 0", held_bad); end
  endtask

  // No mul_done: WAIT occupies cycles 2..65, err shows in cycle 66 with the FSM back in IDLE.
  task automatic test_watchdog;
    int bad = 0;
    clear_inputs();
    request(2'b00, 32'd3, 32'd4);
    for (int c = 1; c <= 67; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (c <= 65 && (err || hilo_we || done)) bad++;
      if (c == 65) begin
        checks++;
        if (state_dbg !== 2'd2) begin errors++; $display("FAIL wdog_c65_state: got %0d expected 2", state_dbg); end
      end
      if (c == 66) begin
        checks++;
        if ({err, done, hilo_we} !== 3'b100 || state_dbg !== 2'd0 || req_ready !== 1'b1) begin
          errors++; $display("FAIL wdog_err_c66: got err/done/we=%b state=%0d ready=%b expected 100 0 1",
            {err, done, hilo_we}, state_dbg, req_ready);
        end
      end
      if (c == 67) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL wdog_err_pulse: got %b expected 0", err); end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wdog_early: got %0d cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    clear_inputs();
    request(2'b10, 32'd50, 32'd5);
    div_q = 32'd10; div_r = 32'd0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (c == 2) div_busy = 1'b1;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, hilo_we, done, err, dbz, mul_start, mulu_start, div_start, divu_start} !== 9'd0 ||
        {op_a, op_b, hi_wdata, lo_wdata} !== 128'd0 || req_ready !== 1'b1 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got flags=%b a=%h b=%h ready=%b state=%0d expected 0 0 0 1 0",
        {busy, hilo_we, done, err, dbz, mul_start, mulu_start, div_start, divu_start}, op_a, op_b, req_ready, state_dbg);
    end
    repeat (2) tick();
    rst = 1'b1;
    div_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || hilo_we || err || state_dbg !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d cycles expected 0", bad); end
  endtask

  task automatic test_dbz;
    int hw_at = -1;
    int dbz_seen = 0;
    clear_inputs();
    request(2'b10, 32'd9, 32'd0);
`ifdef MULDIV_DBZ_BYPASS_EN
    for (int c = 1; c <= 2; c++) begin
      tick();
      if (c == 1) begin
        req_valid = 1'b0;
        checks++;
        if ({hilo_we, done, dbz, err, div_start} !== 5'b11100 || hi_wdata !== 32'd9 || lo_wdata !== 32'hFFFF_FFFF) begin
          errors++; $display("FAIL dbz_bypass_c1: got we/done/dbz/err/start=%b hi=%h lo=%h expected 11100 9 ffffffff",
            {hilo_we, done, dbz, err, div_start}, hi_wdata, lo_wdata);
        end
      end
      if (c == 2) begin
        checks++;
        if (req_ready !== 1'b1 || dbz !== 1'b0 || div_start !== 1'b0) begin
          errors++; $display("FAIL dbz_bypass_c2: got ready=%b dbz=%b start=%b expected 1 0 0", req_ready, dbz, div_start);
        end
      end
    end
`else
    div_q = 32'hFFFF_FFFF; div_r = 32'd9;
    for (int c = 1; c <= 8; c++) begin
      tick();
      div_busy = (c >= 2 && c <= 5);
      if (dbz) dbz_seen++;
      if (hilo_we && hw_at < 0) hw_at = c;
      if (c == 1) begin
        req_valid = 1'b0;
        checks++;
        if (div_start !== 1'b1 || hilo_we !== 1'b0) begin
          errors++; $display("FAIL dbz_dispatch_c1: got start=%b we=%b expected 1 0", div_start, hilo_we);
        end
      end
    end
    checks++;
    if (hw_at != 7 || dbz_seen != 0) begin
      errors++; $display("FAIL dbz_divider_path: got write cycle=%0d dbz cycles=%0d expected 7 0", hw_at, dbz_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_min();
    test_divu();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_dbz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
